rsa_avm_arbiter: RTL and testbench
==================================

Name: rsa_avm_arbiter

Overview:
- Shares one 256-bit Avalon-MM master port (DRAM side) between NUM_REQ RSA wrapper instances, each of which is itself an Avalon-MM master.
- Performs round-robin grant per command and holds the grant while the command is stalled by waitrequest.
- Tracks outstanding reads in an in-order tag FIFO so each readdatavalid beat is routed back to its issuer.
- Sits between the RSA wrappers and the PCIe/DDR interconnect.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..8).
- MAX_PENDING, 4, outstanding-read depth (power of two).
- ID_W, 1, requester index width (= clog2(NUM_REQ), minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rq_address  in  NUM_REQ*32  per-requester address, requester i at [i*32 +: 32].
- rq_read  in  NUM_REQ  per-requester read strobe.
- rq_write  in  NUM_REQ  per-requester write strobe.
- rq_writedata  in  NUM_REQ*256  per-requester write data.
- rq_waitrequest  out  NUM_REQ  per-requester stall.
- rq_readdatavalid  out  NUM_REQ  per-requester read-data valid (one-hot or zero).
- rq_readdata  out  256  read data, broadcast to all requesters.
- m_waitrequest  in  1  downstream stall.
- m_address  out  32  downstream address.
- m_read  out  1  downstream read strobe.
- m_write  out  1  downstream write strobe.
- m_writedata  out  256  downstream write data.
- m_readdatavalid  in  1  downstream read-data valid.
- m_readdata  in  256  downstream read data.
- err_spurious  out  1  sticky flag: readdatavalid received with no read pending.

Behaviour:
- Reset (async) clears the following: state=ARB, grant_id=0, rr_ptr=0, FIFO empty, err_spurious=0. All outputs are 0 except rq_waitrequest, which resets to all-1.
- States:
  - ARB: scan requesters starting at rr_ptr and wrapping modulo NUM_REQ. Pick the first i with rq_write[i], or with rq_read[i] and FIFO not full. Register grant_id=i and go to GRANT. If no requester qualifies, stay in ARB.
  - GRANT: m_address, m_read, m_write and m_writedata are driven combinationally from requester grant_id. rq_waitrequest[grant_id]=m_waitrequest, and all other bits are 1.
- GRANT exit conditions:
  - Command accepted (m_read|m_write and !m_waitrequest): go to ARB, with rr_ptr=grant_id+1 modulo NUM_REQ.
  - Granted requester drops both strobes (Avalon violation): go to ARB next cycle, with no FIFO push and rr_ptr unchanged.
- In ARB, m_read=m_write=0 and all rq_waitrequest bits are 1. Minimum issue cost is 2 cycles per command (1 arbitration, 1 grant); back-to-back issue is not supported.
- Read and write asserted together by one requester: the write takes priority. The read stays pending and competes again in the next arbitration.
- An accepted read pushes grant_id into the tag FIFO. A read is never granted while the FIFO is full, but writes are still granted.
- m_readdatavalid: rq_readdatavalid[head_id]=1 in the same cycle (combinational), rq_readdata=m_readdata, and the FIFO pops. Same-cycle push and pop is legal and leaves the count unchanged.
- m_readdatavalid with an empty FIFO: no rq_readdatavalid is asserted, and err_spurious sets and stays set until reset.
- Reset mid-transaction: all pending tags are discarded. The downstream is expected to be reset together with the arbiter.
- FIFO pointers are ID_W-independent, clog2(MAX_PENDING)+1 bits wide, and wrap naturally. Count has range 0..MAX_PENDING.

Decomposition:
- Package rsa_avm_pkg holds AVM_ADDR_W=32, AVM_DATA_W=256, the arbiter state encoding (ARB=1'b0, GRANT=1'b1), and a round-robin-next helper function.
- Sub-module rsa_arb_tag_fifo holds the synchronous ID FIFO. Its interface is push/pop/din/dout/full/empty; dout is combinational from the head.

Test Plan:
- Single requester 0 reads 0x20 with m_waitrequest=0: m_read=1 with m_address=0x20 in cycle 2. Readdatavalid 3 cycles later produces rq_readdatavalid=2'b01 and rq_readdata=m_readdata.
- Both requesters write continuously: grants alternate 0,1,0,1. m_address alternates between the two rq_address values, with one command per 2 cycles.
- Requester 1 reads with m_waitrequest held 5 cycles: m_read and m_address stay stable for 6 cycles, and rq_waitrequest=2'b11, then 2'b01 on the accept cycle. No grant goes to requester 0 meanwhile.
- Issue 4 reads (MAX_PENDING) with no readdatavalid: the 5th read is withheld. A write from the other requester is still granted. After one readdatavalid, the 5th read issues.
- Interleaved reads 0,1,1,0, then four readdatavalid beats: rq_readdatavalid sequence is 01,10,10,01. Push and pop in the same cycle keep the count correct.
- Readdatavalid with the FIFO empty sets err_spurious=1 with rq_readdatavalid=0. Assert reset mid-grant: all outputs return to reset values and err_spurious=0.

Source files
------------

// File: rtl/rsa_avm_pkg.sv
// Shared definitions for the RSA Avalon-MM arbiter slice.
//   AVM_ADDR_W / AVM_DATA_W : downstream Avalon-MM address and data widths.
//   arb_state_e             : arbiter state encoding.
//   rr_next()               : round-robin successor of an index, modulo a requester count.
package rsa_avm_pkg;

  localparam int unsigned AVM_ADDR_W = 32;
  localparam int unsigned AVM_DATA_W = 256;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
    return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rsa_arb_tag_fifo.sv
// In-order requester-ID FIFO used to route read-data beats back to their issuer.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (empties the FIFO).
//   push, din    : write din at the tail (ignored when full).
//   pop          : drop the head entry (ignored when empty).
//   dout         : head entry, combinational.
//   full, empty  : occupancy flags.
module rsa_arb_tag_fifo
  import rsa_avm_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count;
  logic [Width-1:0] mem_q [Depth];

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW + 1)'(Depth));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rsa_avm_arbiter.sv
// Shares one 256-bit Avalon-MM master port between NUM_REQ Avalon-MM masters.
// Round-robin grant per command, grant held while the command is stalled, and an
// in-order tag FIFO routes each readdatavalid beat back to the requester that issued it.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset.
//   rq_*                 : per-requester Avalon-MM slave side (requester i at slice i).
//   rq_readdata          : read data broadcast to all requesters.
//   m_*                  : downstream Avalon-MM master side.
//   err_spurious         : sticky, set by a readdatavalid beat with no read outstanding.
module rsa_avm_arbiter
  import rsa_avm_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned ID_W        = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*AVM_ADDR_W-1:0] rq_address,
  input  logic [NUM_REQ-1:0]            rq_read,
  input  logic [NUM_REQ-1:0]            rq_write,
  input  logic [NUM_REQ*AVM_DATA_W-1:0] rq_writedata,
  output logic [NUM_REQ-1:0]            rq_waitrequest,
  output logic [NUM_REQ-1:0]            rq_readdatavalid,
  output logic [AVM_DATA_W-1:0]         rq_readdata,
  input  logic                          m_waitrequest,
  output logic [AVM_ADDR_W-1:0]         m_address,
  output logic                          m_read,
  output logic                          m_write,
  output logic [AVM_DATA_W-1:0]         m_writedata,
  input  logic                          m_readdatavalid,
  input  logic [AVM_DATA_W-1:0]         m_readdata,
  output logic                          err_spurious
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0] head_id;

  logic            pick_valid;
  logic [ID_W-1:0] pick_id;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic            sel_write, sel_read;

  logic [AVM_ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [AVM_DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = rq_address[i*AVM_ADDR_W +: AVM_ADDR_W];
    assign wdata_arr[i] = rq_writedata[i*AVM_DATA_W +: AVM_DATA_W];
  end

  // Scan from rr_ptr upwards, wrapping. Reads only qualify while a tag slot is free.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (scan_sum >= (ID_W + 1)'(NUM_REQ)) scan_sum = scan_sum - (ID_W + 1)'(NUM_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!pick_valid && (rq_write[scan_idx] || (rq_read[scan_idx] && !fifo_full))) begin
        pick_valid = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    fifo_push      = 1'b0;
    sel_write      = 1'b0;
    sel_read       = 1'b0;
    m_address      = '0;
    m_writedata    = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    rq_waitrequest = '1;
    unique case (state_q)
      ARB: begin
        if (pick_valid) begin
          grant_d = pick_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Write wins when both strobes are up; the read re-arbitrates afterwards.
        sel_write                = rq_write[grant_q];
        sel_read                 = rq_read[grant_q] & ~sel_write;
        m_address                = addr_arr[grant_q];
        m_writedata              = wdata_arr[grant_q];
        m_write                  = sel_write;
        m_read                   = sel_read;
        rq_waitrequest[grant_q]  = m_waitrequest;
        if ((sel_write || sel_read) && !m_waitrequest) begin
          state_d   = ARB;
          rr_ptr_d  = ID_W'(rr_next(32'(grant_q), NUM_REQ));
          fifo_push = sel_read;
        end else if (!sel_write && !sel_read) begin
          // Requester withdrew its command: release without advancing the pointer.
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (m_readdatavalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign fifo_pop     = m_readdatavalid & ~fifo_empty;
  assign rq_readdata  = m_readdata;
  assign err_spurious = err_q;

  always_comb begin
    rq_readdatavalid = '0;
    if (fifo_pop) rq_readdatavalid[head_id] = 1'b1;
  end

  rsa_arb_tag_fifo #(
    .Depth(MAX_PENDING),
    .Width(ID_W)
  ) u_tag_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (grant_q),
    .dout (head_id),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_rsa_avm_arbiter.sv
// Directed checks followed by a randomized run against a transaction-level model:
// requesters hold commands until their own waitrequest drops, the downstream keeps an
// ordered list of outstanding reads, and each returned beat must reach its issuer.
module tb_rsa_avm_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int MAX_PENDING = 4;
  localparam int ID_W        = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  rq_address;
  logic [1:0]   rq_read, rq_write;
  logic [511:0] rq_writedata;
  logic [1:0]   rq_waitrequest, rq_readdatavalid;
  logic [255:0] rq_readdata;
  logic         m_waitrequest;
  logic [31:0]  m_address;
  logic         m_read, m_write;
  logic [255:0] m_writedata;
  logic         m_readdatavalid;
  logic [255:0] m_readdata;
  logic         err_spurious;

  int tests = 0;
  int fails = 0;

  rsa_avm_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MAX_PENDING(MAX_PENDING),
    .ID_W       (ID_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rq_address      (rq_address),
    .rq_read         (rq_read),
    .rq_write        (rq_write),
    .rq_writedata    (rq_writedata),
    .rq_waitrequest  (rq_waitrequest),
    .rq_readdatavalid(rq_readdatavalid),
    .rq_readdata     (rq_readdata),
    .m_waitrequest   (m_waitrequest),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_readdatavalid (m_readdatavalid),
    .m_readdata      (m_readdata),
    .err_spurious    (err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rd_data(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, a + 32'd7, {4{a ^ 32'hCAFE_0000}}};
  endfunction

  // Starts at a negedge, holds a single read from requester id until accepted.
  task automatic issue_read(input int id, input logic [31:0] a);
    logic        ok;
    logic [31:0] got;
    ok  = 1'b0;
    got = '0;
    rq_read     = '0;
    rq_read[id] = 1'b1;
    rq_address[id*32 +: 32] = a;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (m_read && !m_waitrequest) begin
        ok  = 1'b1;
        got = m_address;
      end
      @(negedge clk);
      if (ok) break;
    end
    rq_read = '0;
    check("issue_ok", ok, 1'b1);
    check("issue_addr", got, a);
  endtask

  logic [1:0]   act, act_wr, exp_rdv;
  logic [31:0]  act_addr [2];
  logic [255:0] act_data [2];
  int           dq_id [$];
  logic [255:0] dq_data [$];
  int           n, n_acc, acc_id;
  logic         ok;
  logic [31:0]  a_got;
  logic         gen;

  initial begin
    reset           = 1'b1;
    rq_address      = '0;
    rq_read         = '0;
    rq_write        = '0;
    rq_writedata    = '0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_waitreq", rq_waitrequest, 2'b11);
    check("rst_m_read", m_read, 1'b0);
    check("rst_m_write", m_write, 1'b0);
    check("rst_m_addr", m_address, 32'h0);
    check("rst_rdv", rq_readdatavalid, 2'b00);
    check("rst_err", err_spurious, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Single read from requester 0
    rq_read             = 2'b01;
    rq_address[31:0]    = 32'h20;
    #1;
    check("t1_arb_idle", m_read, 1'b0);
    @(negedge clk);
    #1;
    check("t1_grant", {m_read, m_write, m_address, rq_waitrequest}, {1'b1, 1'b0, 32'h20, 2'b10});
    @(negedge clk);
    rq_read = 2'b00;
    @(negedge clk);
    @(negedge clk);
    m_readdatavalid = 1'b1;
    m_readdata      = {8{32'hDEAD_0001}};
    #1;
    check("t1_rdv", rq_readdatavalid, 2'b01);
    check("t1_rdata", rq_readdata, {8{32'hDEAD_0001}});
    @(negedge clk);
    m_readdatavalid = 1'b0;

    // Both requesters write continuously: grants alternate, one command per 2 cycles
    rq_write                = 2'b11;
    rq_address[31:0]        = 32'h100;
    rq_address[63:32]       = 32'h200;
    rq_writedata[255:0]     = {8{32'h1111_1111}};
    rq_writedata[511:256]   = {8{32'h2222_2222}};
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_write && !m_waitrequest) begin
        check("rr_addr", m_address, (n % 2 == 0) ? 32'h200 : 32'h100);
        check("rr_wdata", m_writedata, (n % 2 == 0) ? {8{32'h2222_2222}} : {8{32'h1111_1111}});
        n++;
      end
      @(negedge clk);
    end
    check("rr_count", n, 4);

    // Requester 1 read held by downstream waitrequest; requester 0 write must not get in
    rq_write          = 2'b01;
    rq_read           = 2'b10;
    rq_address[63:32] = 32'h300;
    m_waitrequest     = 1'b1;
    #1;
    check("t3_arb_idle", m_read, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check("t3_stall", {m_read, m_write, m_address, rq_waitrequest},
            {1'b1, 1'b0, 32'h300, 2'b11});
    end
    @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    check("t3_accept", {m_read, m_write, m_address, rq_waitrequest},
          {1'b1, 1'b0, 32'h300, 2'b01});
    @(negedge clk);
    rq_read         = 2'b00;
    rq_write        = 2'b00;
    m_readdatavalid = 1'b1;
    m_readdata      = {8{32'hBEEF_0003}};
    #1;
    check("t3_rdv", rq_readdatavalid, 2'b10);
    check("t3_rdata", rq_readdata, {8{32'hBEEF_0003}});
    @(negedge clk);
    m_readdatavalid = 1'b0;

    // Fill the tag FIFO; the fifth read waits but a write still gets through
    rq_read          = 2'b01;
    rq_address[31:0] = 32'h400;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_read && !m_waitrequest) n++;
      @(negedge clk);
    end
    check("t4_fill", n, 4);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_read) n++;
      @(negedge clk);
    end
    check("t4_withheld", n, 0);
    rq_write              = 2'b10;
    rq_address[63:32]     = 32'h500;
    rq_writedata[511:256] = {8{32'h5555_0005}};
    #1;
    @(negedge clk);
    #1;
    check("t4_write_full", {m_write, m_read, m_address}, {1'b1, 1'b0, 32'h500});
    @(negedge clk);
    rq_write        = 2'b00;
    m_readdatavalid = 1'b1;
    m_readdata      = rd_data(32'h400);
    #1;
    check("t4_pop_rdv", rq_readdatavalid, 2'b01);
    @(negedge clk);
    m_readdatavalid  = 1'b0;
    rq_address[31:0] = 32'h440;
    ok    = 1'b0;
    a_got = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_read && !m_waitrequest) begin
        ok    = 1'b1;
        a_got = m_address;
      end
      @(negedge clk);
      if (ok) break;
    end
    check("t4_fifth_ok", ok, 1'b1);
    check("t4_fifth_addr", a_got, 32'h440);
    rq_read = 2'b00;
    for (int c = 0; c < 4; c++) begin
      m_readdatavalid = 1'b1;
      m_readdata      = {8{$urandom}};
      #1;
      check("t4_drain", rq_readdatavalid, 2'b01);
      @(negedge clk);
    end
    m_readdatavalid = 1'b0;

    // Interleaved reads 0,1,1,0 with the last push coinciding with the first pop
    issue_read(0, 32'h600);
    issue_read(1, 32'h610);
    issue_read(1, 32'h620);
    rq_read          = 2'b01;
    rq_address[31:0] = 32'h630;
    #1;
    @(negedge clk);
    m_readdatavalid = 1'b1;
    m_readdata      = rd_data(32'h600);
    #1;
    check("t5_push_pop", {m_read, rq_readdatavalid}, {1'b1, 2'b01});
    check("t5_rdata", rq_readdata, rd_data(32'h600));
    @(negedge clk);
    rq_read = 2'b00;
    for (int k = 0; k < 3; k++) begin
      m_readdata = {8{$urandom}};
      #1;
      check("t5_order", rq_readdatavalid, (k == 2) ? 2'b01 : 2'b10);
      @(negedge clk);
    end

    // Read and write together: the write goes first, the read follows
    m_readdatavalid  = 1'b0;
    rq_read          = 2'b01;
    rq_write         = 2'b01;
    rq_address[31:0] = 32'h800;
    #1;
    @(negedge clk);
    #1;
    check("prio_write", {m_write, m_read}, 2'b10);
    @(negedge clk);
    rq_write = 2'b00;
    #1;
    @(negedge clk);
    #1;
    check("prio_read", {m_write, m_read, m_address}, {1'b0, 1'b1, 32'h800});
    @(negedge clk);
    rq_read         = 2'b00;
    m_readdatavalid = 1'b1;
    #1;
    check("prio_rdv", rq_readdatavalid, 2'b01);
    @(negedge clk);

    // Spurious beat with nothing outstanding
    #1;
    check("spur_rdv", rq_readdatavalid, 2'b00);
    check("spur_err_pre", err_spurious, 1'b0);
    @(negedge clk);
    m_readdatavalid = 1'b0;
    #1;
    check("spur_err_set", err_spurious, 1'b1);
    @(negedge clk);
    #1;
    check("spur_err_sticky", err_spurious, 1'b1);
    @(negedge clk);

    // Reset asserted while a write is granted
    rq_write              = 2'b10;
    rq_address[63:32]     = 32'h700;
    rq_writedata[511:256] = {8{32'h7777_0007}};
    #1;
    @(negedge clk);
    #1;
    check("mid_grant", m_write, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_write", m_write, 1'b0);
    check("mid_rst_read", m_read, 1'b0);
    check("mid_rst_addr", m_address, 32'h0);
    check("mid_rst_wdata", m_writedata, 256'h0);
    check("mid_rst_waitreq", rq_waitrequest, 2'b11);
    check("mid_rst_err", err_spurious, 1'b0);
    @(negedge clk);
    reset    = 1'b0;
    rq_write = 2'b00;

    // Randomized traffic against the transaction model
    act    = '0;
    act_wr = '0;
    gen    = 1'b1;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (cyc == 1000) gen = 1'b0;
      if (!gen && act == 2'b00 && dq_id.size() == 0) break;
      for (int i = 0; i < 2; i++) begin
        if (gen && !act[i] && $urandom_range(0, 1) == 1) begin
          act[i]      = 1'b1;
          act_wr[i]   = 1'($urandom_range(0, 1));
          act_addr[i] = {4'(i), 24'($urandom), 4'h0};
          act_data[i] = {8{$urandom}};
        end
        rq_read[i]                = act[i] & ~act_wr[i];
        rq_write[i]               = act[i] & act_wr[i];
        rq_address[i*32 +: 32]    = act_addr[i];
        rq_writedata[i*256 +: 256] = act_data[i];
      end
      m_waitrequest = ($urandom_range(0, 3) == 0);
      if (dq_id.size() > 0 && $urandom_range(0, 2) == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata      = dq_data[0];
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata      = {8{$urandom}};
      end
      #1;
      if (m_readdatavalid) begin
        exp_rdv = (dq_id[0] == 0) ? 2'b01 : 2'b10;
        check("rnd_rdv", rq_readdatavalid, exp_rdv);
        check("rnd_rdata", rq_readdata, dq_data[0]);
        void'(dq_id.pop_front());
        void'(dq_data.pop_front());
      end else begin
        check("rnd_rdv_idle", rq_readdatavalid, 2'b00);
      end
      n_acc  = 0;
      acc_id = 0;
      for (int i = 0; i < 2; i++) begin
        if (act[i] && !rq_waitrequest[i]) begin
          n_acc++;
          acc_id = i;
        end
      end
      check("rnd_single_acc", (n_acc <= 1), 1'b1);
      check("rnd_ds_acc", ((m_read || m_write) && !m_waitrequest), (n_acc == 1));
      if (n_acc == 1) begin
        check("rnd_cmd", {m_write, m_read}, act_wr[acc_id] ? 2'b10 : 2'b01);
        check("rnd_addr", m_address, act_addr[acc_id]);
        if (act_wr[acc_id]) begin
          check("rnd_wdata", m_writedata, act_data[acc_id]);
        end else begin
          check("rnd_pending", (dq_id.size() < MAX_PENDING), 1'b1);
          dq_id.push_back(acc_id);
          dq_data.push_back(rd_data(act_addr[acc_id]));
        end
        act[acc_id] = 1'b0;
      end
      @(negedge clk);
    end
    rq_read         = '0;
    rq_write        = '0;
    m_readdatavalid = 1'b0;
    check("rnd_drained", (act == 2'b00 && dq_id.size() == 0), 1'b1);
    check("rnd_no_spurious", err_spurious, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
